lswb_unit: RTL and testbench
============================

LSWB_UNIT -- requirements
Module: lswb_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid  in  1  EX bundle valid; in_ready  out  1  unit can accept a bundle.
REQ-003 SHALL have ports: funct3 in 3; R_wen in 1; mem_wen in 1; mem_ren in 1; rd in 5; pc in 32; jump_flag in 1; branch_flag in 1; branch_pc in 32; rs2_value in 32; rd_value in 32; Ex_result in 32 -- the EX-stage output bundle.
REQ-004 SHALL have ports: mem_req out 1; mem_we out 1; mem_addr out 32 (word-aligned); mem_wdata out 32; mem_wstrb out 4; mem_gnt in 1; mem_rvalid in 1; mem_rdata in 32.
REQ-005 SHALL have ports: wb_en out 1; wb_rd out 5; wb_data out 32 -- register-file write port.
REQ-006 SHALL have ports: redirect_valid out 1; redirect_pc out 32 -- fetch redirect.
REQ-007 SHALL have ports: trap out 1; trap_addr out 32 (present only with LSWB_MISALIGN_TRAP_EN).

Function
REQ-010 SHALL implement FSM states IDLE, REQ, RESP; in_ready = (state==IDLE).
REQ-011 SHALL accept a bundle on in_valid && in_ready and register all its fields.
REQ-012 Non-memory bundle: SHALL stay in IDLE; one cycle after acceptance SHALL pulse wb_en for one cycle when R_wen && rd!=0, with wb_data = rd_value if jump_flag else Ex_result.
REQ-013 Store (mem_wen): IDLE->REQ; SHALL hold mem_req=1, mem_we=1 and stable addr/wdata/wstrb until mem_gnt; REQ->IDLE on gnt; no writeback.
REQ-014 Load (mem_ren): IDLE->REQ with mem_we=0; REQ->RESP on gnt; RESP->IDLE on mem_rvalid; wb_en pulses the cycle after rvalid (if rd!=0).
REQ-015 Address = Ex_result; mem_addr = {Ex_result[31:2],2'b00}; off = Ex_result[1:0].
REQ-016 Stores: SB strb=4'b0001<<off, data=rs2[7:0] replicated x4; SH strb=4'b0011<<off, data=rs2[15:0] replicated x2; SW strb=4'b1111, data=rs2.
REQ-017 Loads: LB/LBU select byte off, sign/zero extend; LH/LHU select halfword off[1], sign/zero extend; LW whole word; any other funct3 SHALL behave as LW.
REQ-018 Misaligned: LH/LHU/SH with off[0]=1, LW/SW with off!=0.
REQ-019 redirect_valid SHALL pulse one cycle after acceptance when jump_flag, or branch_flag && Ex_result[0]; redirect_pc = branch_pc.
REQ-020 mem_gnt and mem_rvalid arriving in the same cycle while in REQ SHALL be treated as gnt then rvalid: wb_en pulses the next cycle and the state returns to IDLE.
REQ-021 mem_rvalid outside RESP and mem_gnt outside REQ SHALL be ignored.
REQ-022 mem_ren && mem_wen both set SHALL be treated as a store.

Reset
REQ-030 On rst_n low, SHALL asynchronously force state=IDLE; in_ready=1 after release; mem_req, mem_we, wb_en, redirect_valid, trap = 0; mem_addr, mem_wdata, wb_data, wb_rd, redirect_pc, trap_addr = 0; mem_wstrb = 0.
REQ-031 Reset during REQ/RESP SHALL abandon the access; a late rvalid after reset SHALL be ignored.

Configuration
REQ-040 Macro LSWB_MISALIGN_TRAP_EN defined: a misaligned access SHALL issue no mem_req and no wb_en; trap pulses one cycle after acceptance with trap_addr = Ex_result.
REQ-041 Macro undefined: no trap ports; off SHALL be truncated to natural alignment (SH/LH ignore off[0], SW/LW ignore off) and the access proceeds normally.

Structure
REQ-050 SHALL use shared package lswb_pkg holding the state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-051 SHALL use one combinational sub-module lsu_align for strobe/data lane placement and load extraction/extension.

Verification
REQ-060 ALU op, R_wen=1, rd=5, Ex_result=0x1234 -> wb_en pulse next cycle, wb_rd=5, wb_data=0x1234; rd=0 -> no wb_en.
REQ-061 SB with Ex_result=0x1003, rs2=0xAB, gnt after 3 cycles -> mem_req held 3 cycles, addr 0x1000, strb 4'b1000, wdata 0xABABABAB.
REQ-062 LB at 0x2001 with rdata=0x0000_8000 -> wb_data=0xFFFFFF80; LBU -> 0x00000080; LHU at 0x2002 with rdata=0xBEEF0000 -> 0x0000BEEF.
REQ-063 Load with gnt and rvalid in the same cycle -> wb_en the next cycle; in_ready high again that cycle.
REQ-064 JAL: jump_flag=1, rd_value=0x104, branch_pc=0x200 -> wb_data=0x104 and redirect_valid with redirect_pc=0x200.
REQ-065 LW at 0x3002 with macro defined -> trap, trap_addr=0x3002, no mem_req; without macro -> access at 0x3000.

Source files
------------

// File: rtl/lswb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lswb_pkg
// Description : Shared FSM state type, funct3 codes and access-size helpers
//               for the load/store/writeback unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lswb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Access size code: 0 = byte, 1 = halfword, 2 = word (unknown codes act as word)
   function automatic logic [1:0] acc_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return 2'd0;
         F3_H, F3_HU: return 2'd1;
         default:     return 2'd2;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (acc_size(f3))
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         default: return (off != 2'b00);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lswb_unit_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane placement of store data/strobes and extraction with
//               sign/zero extension of load data. Offsets are truncated to the
//               natural alignment of the access size.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
   import lswb_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wsrc_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sext;

   // Lane placement and load extraction by access size
   always_comb begin
      sext     = ~funct3_i[2];
      wstrb_o  = 4'b1111;
      wdata_o  = wsrc_i;
      rdata_o  = rdata_i;
      byte_sel = rdata_i[7:0];
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (off_i)
         2'b00:   byte_sel = rdata_i[7:0];
         2'b01:   byte_sel = rdata_i[15:8];
         2'b10:   byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      case (acc_size(funct3_i))
         2'd0: begin
            wstrb_o = 4'b0001 << off_i;
            wdata_o = {4{wsrc_i[7:0]}};
            rdata_o = {{24{byte_sel[7] & sext}}, byte_sel};
         end
         2'd1: begin
            wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wsrc_i[15:0]}};
            rdata_o = {{16{half_sel[15] & sext}}, half_sel};
         end
         default: begin
            wstrb_o = 4'b1111;
            wdata_o = wsrc_i;
            rdata_o = rdata_i;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lswb_unit.sv
`default_nettype none
// ============================================================================
// Module      : lswb_unit
// Description : Load/store/writeback stage. Accepts one EX bundle at a time,
//               runs a single memory request/response handshake for loads and
//               stores, writes the register file and raises fetch redirects.
//               Define LSWB_MISALIGN_TRAP_EN to trap misaligned accesses
//               (adds trap/trap_addr ports); otherwise offsets are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module lswb_unit
   import lswb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  funct3,
   input  logic        R_wen,
   input  logic        mem_wen,
   input  logic        mem_ren,
   input  logic [4:0]  rd,
   input  logic [31:0] pc,
   input  logic        jump_flag,
   input  logic        branch_flag,
   input  logic [31:0] branch_pc,
   input  logic [31:0] rs2_value,
   input  logic [31:0] rd_value,
   input  logic [31:0] Ex_result,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
`ifdef LSWB_MISALIGN_TRAP_EN
   ,
   output logic        trap,
   output logic [31:0] trap_addr
`endif
);
   state_t      state_q, state_d;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [4:0]  rd_q;
   logic        is_store_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [3:0]  mem_wstrb_q;
   logic        wb_en_q, redirect_valid_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q, redirect_pc_q;

   logic        accept, is_mem, is_store, misaligned, go_mem, load_done;
   logic [2:0]  al_f3;
   logic [1:0]  al_off;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, al_rdata;
   logic        unused_pc;

   assign unused_pc = ^pc;
   assign accept    = in_valid & in_ready;
   assign is_mem    = mem_wen | mem_ren;
   assign is_store  = mem_wen;
`ifdef LSWB_MISALIGN_TRAP_EN
   assign misaligned = is_mem & is_misaligned(funct3, Ex_result[1:0]);
`else
   assign misaligned = 1'b0;
`endif
   assign go_mem    = is_mem & ~misaligned;
   assign load_done = ~is_store_q & mem_rvalid &
                      (((state_q == ST_REQ) & mem_gnt) | (state_q == ST_RESP));

   // While idle the aligner works on the incoming bundle (store placement);
   // during an access it works on the registered load attributes.
   assign al_f3  = (state_q == ST_IDLE) ? funct3 : funct3_q;
   assign al_off = (state_q == ST_IDLE) ? Ex_result[1:0] : off_q;

   lsu_align u_align (
      .funct3_i (al_f3),
      .off_i    (al_off),
      .wsrc_i   (rs2_value),
      .rdata_i  (mem_rdata),
      .wstrb_o  (al_wstrb),
      .wdata_o  (al_wdata),
      .rdata_o  (al_rdata)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake outputs; gnt+rvalid together in REQ completes the load
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && go_mem) state_d = ST_REQ;
         end
         ST_REQ: begin
            mem_req = 1'b1;
            mem_we  = is_store_q;
            if (mem_gnt) state_d = (is_store_q || mem_rvalid) ? ST_IDLE : ST_RESP;
         end
         ST_RESP: begin
            if (mem_rvalid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bundle capture, memory request fields and one-cycle writeback/redirect pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_q         <= 3'd0;
         off_q            <= 2'd0;
         rd_q             <= 5'd0;
         is_store_q       <= 1'b0;
         mem_addr_q       <= 32'd0;
         mem_wdata_q      <= 32'd0;
         mem_wstrb_q      <= 4'd0;
         wb_en_q          <= 1'b0;
         wb_rd_q          <= 5'd0;
         wb_data_q        <= 32'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
      end else begin
         wb_en_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         if (accept) begin
            funct3_q         <= funct3;
            off_q            <= Ex_result[1:0];
            rd_q             <= rd;
            is_store_q       <= is_store;
            redirect_valid_q <= jump_flag | (branch_flag & Ex_result[0]);
            redirect_pc_q    <= branch_pc;
            if (go_mem) begin
               mem_addr_q  <= {Ex_result[31:2], 2'b00};
               mem_wstrb_q <= is_store ? al_wstrb : 4'd0;
               mem_wdata_q <= is_store ? al_wdata : 32'd0;
            end else if (!is_mem && R_wen && rd != 5'd0) begin
               wb_en_q   <= 1'b1;
               wb_rd_q   <= rd;
               wb_data_q <= jump_flag ? rd_value : Ex_result;
            end
         end
         if (load_done && rd_q != 5'd0) begin
            wb_en_q   <= 1'b1;
            wb_rd_q   <= rd_q;
            wb_data_q <= al_rdata;
         end
      end
   end

`ifdef LSWB_MISALIGN_TRAP_EN
   logic        trap_q;
   logic [31:0] trap_addr_q;

   // Misaligned accesses never reach memory; report them one cycle after acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q      <= 1'b0;
         trap_addr_q <= 32'd0;
      end else begin
         trap_q <= accept & misaligned;
         if (accept && misaligned) trap_addr_q <= Ex_result;
      end
   end

   assign trap      = trap_q;
   assign trap_addr = trap_addr_q;
`endif

   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_wstrb      = mem_wstrb_q;
   assign wb_en          = wb_en_q;
   assign wb_rd          = wb_rd_q;
   assign wb_data        = wb_data_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_lswb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_lswb_unit
// Description : Self-checking bench for lswb_unit: directed vector table,
//               hand-written corner sequences and randomized transactions
//               checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lswb_unit;
   import lswb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [2:0]  funct3 = 3'd0;
   logic        R_wen = 1'b0, mem_wen = 1'b0, mem_ren = 1'b0;
   logic [4:0]  rd = 5'd0;
   logic [31:0] pc = 32'd0;
   logic        jump_flag = 1'b0, branch_flag = 1'b0;
   logic [31:0] branch_pc = 32'd0, rs2_value = 32'd0, rd_value = 32'd0, Ex_result = 32'd0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef LSWB_MISALIGN_TRAP_EN
   logic        trap;
   logic [31:0] trap_addr;
`endif

   always #5 clk = ~clk;

   lswb_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .R_wen(R_wen), .mem_wen(mem_wen), .mem_ren(mem_ren),
      .rd(rd), .pc(pc), .jump_flag(jump_flag), .branch_flag(branch_flag),
      .branch_pc(branch_pc), .rs2_value(rs2_value), .rd_value(rd_value),
      .Ex_result(Ex_result), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef LSWB_MISALIGN_TRAP_EN
      , .trap(trap), .trap_addr(trap_addr)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_load;
      logic        both;
      logic [2:0]  f3;
      logic [31:0] ex;
      logic [31:0] rs2;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          gdly;
      int          rdly;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_wb;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic both, input logic [2:0] f3,
                               input logic [31:0] ex, input logic [31:0] rs2,
                               input logic [31:0] rdata, input logic [4:0] r,
                               input int g, input int rv, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] wd,
                               input logic [31:0] wb);
      vec_t v;
      v.is_load = ld; v.both = both; v.f3 = f3; v.ex = ex; v.rs2 = rs2;
      v.rdata = rdata; v.rd = r; v.gdly = g; v.rdly = rv;
      v.e_addr = a; v.e_strb = s; v.e_wdata = wd; v.e_wb = wb;
      return v;
   endfunction

   // Reference behaviour: natural-alignment truncation, lane placement, extension
   function automatic void model_mem(input logic [2:0] f3, input logic [31:0] ex,
                                     input logic [31:0] rs2, input logic [31:0] rdata,
                                     output logic [31:0] addr, output logic [3:0] strb,
                                     output logic [31:0] wdata, output logic [31:0] ld);
      int sz, off;
      logic [31:0] mask, lane;
      sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off  = int'(ex[1:0]);
      off  = off - (off % sz);
      addr = ex & 32'hFFFF_FFFC;
      strb = 4'(((1 << sz) - 1) << off);
      if (sz == 1)      wdata = {24'h0, rs2[7:0]} * 32'h0101_0101;
      else if (sz == 2) wdata = {16'h0, rs2[15:0]} * 32'h0001_0001;
      else              wdata = rs2;
      lane = rdata >> (8 * off);
      if (sz == 4) ld = rdata;
      else begin
         mask = (32'h1 << (8 * sz)) - 32'h1;
         ld   = lane & mask;
         if (!f3[2] && ld[8*sz-1]) ld = ld | ~mask;
      end
   endfunction

   // Called at a negedge; returns at a negedge
   task automatic mem_txn(input vec_t v);
      in_valid = 1'b1; funct3 = v.f3; mem_wen = !v.is_load; mem_ren = v.is_load | v.both;
      R_wen = v.is_load; rd = v.rd; Ex_result = v.ex; rs2_value = v.rs2;
      jump_flag = 1'b0; branch_flag = 1'b0; rd_value = $urandom; branch_pc = $urandom;
      @(negedge clk);
      in_valid = 1'b0; mem_wen = 1'b0; mem_ren = 1'b0; R_wen = 1'b0;
      funct3 = 3'($urandom); Ex_result = $urandom; rs2_value = $urandom;
      for (int n = 1; n <= v.gdly; n++) begin
         chk("mem_req", mem_req, 1'b1);
         chk("mem_we", mem_we, !v.is_load);
         chk("mem_addr", mem_addr, v.e_addr);
         if (!v.is_load) begin
            chk("mem_wstrb", mem_wstrb, v.e_strb);
            chk("mem_wdata", mem_wdata, v.e_wdata);
         end
         if (n == v.gdly) begin
            mem_gnt = 1'b1;
            if (v.is_load && v.rdly == 0) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; end
         end else begin
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         end
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      chk("mem_req_drop", mem_req, 1'b0);
      if (v.is_load) begin
         for (int k = 1; k <= v.rdly; k++) begin
            chk("wb_early", wb_en, 1'b0);
            chk("in_ready_resp", in_ready, 1'b0);
            if (k == v.rdly) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; end
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = $urandom;
         end
      end
      chk("in_ready_back", in_ready, 1'b1);
      chk("wb_en", wb_en, v.is_load && v.rd != 5'd0);
      if (v.is_load && v.rd != 5'd0) begin
         chk("wb_rd", wb_rd, v.rd);
         chk("wb_data", wb_data, v.e_wb);
      end
      @(negedge clk);
      chk("wb_pulse_end", wb_en, 1'b0);
   endtask

   task automatic alu_txn(input logic rwen, input logic [4:0] r, input logic [31:0] ex,
                          input logic [31:0] rv, input logic j, input logic b,
                          input logic [31:0] bpc);
      logic exp_wb, exp_rdr;
      in_valid = 1'b1; mem_wen = 1'b0; mem_ren = 1'b0; R_wen = rwen; rd = r;
      Ex_result = ex; rd_value = rv; jump_flag = j; branch_flag = b; branch_pc = bpc;
      funct3 = 3'($urandom);
      @(negedge clk);
      in_valid = 1'b0; R_wen = 1'b0; jump_flag = 1'b0; branch_flag = 1'b0;
      Ex_result = $urandom; rd_value = $urandom; branch_pc = $urandom;
      exp_wb  = rwen && (r != 5'd0);
      exp_rdr = j || (b && ex[0]);
      chk("alu_wb_en", wb_en, exp_wb);
      if (exp_wb) begin
         chk("alu_wb_rd", wb_rd, r);
         chk("alu_wb_data", wb_data, j ? rv : ex);
      end
      chk("redirect_valid", redirect_valid, exp_rdr);
      if (exp_rdr) chk("redirect_pc", redirect_pc, bpc);
      chk("alu_mem_req", mem_req, 1'b0);
      chk("alu_in_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("alu_wb_end", wb_en, 1'b0);
      chk("redirect_end", redirect_valid, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   kind;
      logic [31:0] a, wd, wb;
      logic [3:0]  s;

      tbl[0]  = mk(0, 0, F3_B,  32'h1003, 32'hAB,       32'h0,         5'd0, 3, 0, 32'h1000, 4'b1000, 32'hABABABAB, 32'h0);
      tbl[1]  = mk(1, 0, F3_B,  32'h2001, 32'h0,        32'h0000_8000, 5'd7, 1, 1, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_FF80);
      tbl[2]  = mk(1, 0, F3_BU, 32'h2001, 32'h0,        32'h0000_8000, 5'd8, 2, 2, 32'h2000, 4'b0000, 32'h0, 32'h0000_0080);
      tbl[3]  = mk(1, 0, F3_HU, 32'h2002, 32'h0,        32'hBEEF_0000, 5'd9, 2, 0, 32'h2000, 4'b0000, 32'h0, 32'h0000_BEEF);
      tbl[4]  = mk(1, 0, F3_H,  32'h2002, 32'h0,        32'h8001_0000, 5'd10, 1, 0, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001);
      tbl[5]  = mk(0, 0, F3_H,  32'h1006, 32'h1234_5678, 32'h0,        5'd0, 1, 0, 32'h1004, 4'b1100, 32'h5678_5678, 32'h0);
      tbl[6]  = mk(0, 0, F3_W,  32'h1008, 32'hDEAD_BEEF, 32'h0,        5'd0, 2, 0, 32'h1008, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      tbl[7]  = mk(1, 0, F3_W,  32'h4000, 32'h0,        32'hCAFE_F00D, 5'd11, 1, 3, 32'h4000, 4'b0000, 32'h0, 32'hCAFE_F00D);
      tbl[8]  = mk(1, 0, F3_B,  32'h2003, 32'h0,        32'h7F00_0000, 5'd12, 3, 1, 32'h2000, 4'b0000, 32'h0, 32'h0000_007F);
      tbl[9]  = mk(1, 0, 3'b011, 32'h4004, 32'h0,       32'h1234_5678, 5'd13, 1, 1, 32'h4004, 4'b0000, 32'h0, 32'h1234_5678);
      tbl[10] = mk(1, 0, F3_W,  32'h4008, 32'h0,        32'h5555_AAAA, 5'd0, 1, 1, 32'h4008, 4'b0000, 32'h0, 32'h0);
      tbl[11] = mk(0, 1, F3_B,  32'h1011, 32'h0000_00C3, 32'h0,        5'd14, 1, 0, 32'h1010, 4'b0010, 32'hC3C3C3C3, 32'h0);

      // Reset values
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wstrb", mem_wstrb, 4'h0);
      chk("rst_wb_en", wb_en, 1'b0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_rd", wb_rd, 5'h0);
      chk("rst_redirect", redirect_valid, 1'b0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);

      // Vector table
      for (int i = 0; i < 12; i++) mem_txn(tbl[i]);

      // Non-memory bundles, jump and branch redirects
      alu_txn(1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0);
      alu_txn(1'b1, 5'd0, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0);
      alu_txn(1'b1, 5'd1, 32'h200, 32'h104, 1'b1, 1'b0, 32'h200);
      alu_txn(1'b0, 5'd3, 32'h1, 32'h0, 1'b0, 1'b1, 32'h800);
      alu_txn(1'b0, 5'd3, 32'h0, 32'h0, 1'b0, 1'b1, 32'h900);

      // Stray gnt/rvalid while idle are ignored
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("stray_wb_en", wb_en, 1'b0);
      chk("stray_mem_req", mem_req, 1'b0);
      chk("stray_in_ready", in_ready, 1'b1);

      // Word load at an unaligned address
`ifdef LSWB_MISALIGN_TRAP_EN
      in_valid = 1'b1; funct3 = F3_W; mem_ren = 1'b1; mem_wen = 1'b0; R_wen = 1'b1;
      rd = 5'd4; Ex_result = 32'h3002;
      @(negedge clk);
      in_valid = 1'b0; mem_ren = 1'b0; R_wen = 1'b0; Ex_result = 32'h0;
      chk("trap", trap, 1'b1);
      chk("trap_addr", trap_addr, 32'h3002);
      chk("trap_mem_req", mem_req, 1'b0);
      chk("trap_wb_en", wb_en, 1'b0);
      @(negedge clk);
      chk("trap_end", trap, 1'b0);
      chk("trap_mem_req2", mem_req, 1'b0);
`else
      mem_txn(mk(1, 0, F3_W, 32'h3002, 32'h0, 32'h0BAD_F00D, 5'd4, 1, 1,
                 32'h3000, 4'b0000, 32'h0, 32'h0BAD_F00D));
`endif

      // Reset during an outstanding load abandons it; late rvalid ignored
      in_valid = 1'b1; funct3 = F3_W; mem_ren = 1'b1; mem_wen = 1'b0; R_wen = 1'b1;
      rd = 5'd6; Ex_result = 32'h5000;
      @(negedge clk);
      in_valid = 1'b0; mem_ren = 1'b0; R_wen = 1'b0;
      chk("pre_rst_mem_req", mem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_req", mem_req, 1'b0);
      chk("async_rst_in_ready", in_ready, 1'b1);
      chk("async_rst_mem_addr", mem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h2468_ACE0;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("late_rvalid_wb_en", wb_en, 1'b0);
      chk("late_rvalid_in_ready", in_ready, 1'b1);
      chk("late_rvalid_mem_req", mem_req, 1'b0);

      // Randomized transactions against the reference model
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            alu_txn(1'($urandom), 5'($urandom), $urandom, $urandom,
                    1'($urandom_range(0, 3) == 0), 1'($urandom), $urandom);
         end else begin
            v.is_load = (kind == 1);
            v.both    = !v.is_load && ($urandom_range(0, 3) == 0);
            v.f3      = v.is_load ? 3'($urandom) : 3'($urandom_range(0, 2));
            v.ex      = $urandom;
`ifdef LSWB_MISALIGN_TRAP_EN
            v.ex[1:0] = 2'b00;
`endif
            v.rs2     = $urandom;
            v.rdata   = $urandom;
            v.rd      = 5'($urandom);
            v.gdly    = $urandom_range(1, 4);
            v.rdly    = $urandom_range(0, 3);
            model_mem(v.f3, v.ex, v.rs2, v.rdata, a, s, wd, wb);
            v.e_addr = a; v.e_strb = s; v.e_wdata = wd; v.e_wb = wb;
            mem_txn(v);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
